// File: rtl/gpr_mp_if.sv
// rtl/gpr_mp_if.sv - register file read/write/reserve bus bundle
interface gpr_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       flush;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_ready;
    logic                       wa_en;
    logic [ADDR_W-1:0]          wa_addr;
    logic [DATA_W/8-1:0]        wa_be;
    logic [DATA_W-1:0]          wa_data;
    logic                       wb_en;
    logic [ADDR_W-1:0]          wb_addr;
    logic [DATA_W/8-1:0]        wb_be;
    logic [DATA_W-1:0]          wb_data;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic                       rsv_ok;
    logic [DATA_W-1:0]          tap_out;

    modport master (
        output flush, rd_addr, wa_en, wa_addr, wa_be, wa_data,
               wb_en, wb_addr, wb_be, wb_data, rsv_en, rsv_addr,
        input  rd_data, rd_ready, rsv_ok, tap_out
    );

    modport slave (
        input  flush, rd_addr, wa_en, wa_addr, wa_be, wa_data,
               wb_en, wb_addr, wb_be, wb_data, rsv_en, rsv_addr,
        output rd_data, rd_ready, rsv_ok, tap_out
    );
endinterface

// File: rtl/gpr_mp.sv
// rtl/gpr_mp.sv - multi-port register file with byte-merged writes and pending scoreboard
module gpr_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int TAP_IDX  = 5
) (
    input  logic     clk,
    input  logic     rst,
    gpr_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] TAP_A = ADDR_W'(TAP_IDX);

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("gpr_mp: DATA_W must be a multiple of 8");
    end
    if (TAP_IDX < 0 || TAP_IDX >= DEPTH) begin : g_bad_tap
        $error("gpr_mp: TAP_IDX out of range");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic [DATA_W-1:0] w_next [DEPTH];
    logic [DEPTH-1:0]  w_clr;
    logic              w_rsv_ok;

    // Post-edge value of every register; reads take it from here, which gives the bypass.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            w_next[r] = r_mem[r];
            for (int k = 0; k < NB; k++) begin
                if (bus.wb_en && bus.wb_addr == ADDR_W'(r) && bus.wb_be[k])
                    w_next[r][k*8 +: 8] = bus.wb_data[k*8 +: 8];
                else if (bus.wa_en && bus.wa_addr == ADDR_W'(r) && bus.wa_be[k])
                    w_next[r][k*8 +: 8] = bus.wa_data[k*8 +: 8];
            end
            if (ZERO_REG != 0 && r == 0)
                w_next[r] = '0;
            w_clr[r] = (bus.wa_en && bus.wa_addr == ADDR_W'(r) && (|bus.wa_be)) ||
                       (bus.wb_en && bus.wb_addr == ADDR_W'(r) && (|bus.wb_be));
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_ra;
        bus.rd_data  = '0;
        bus.rd_ready = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
            bus.rd_data[i*DATA_W +: DATA_W] = w_next[w_ra];
            bus.rd_ready[i] = !r_pend[w_ra] || w_clr[w_ra];
        end
    end

    // Register 0 never gets its pending bit set when hardwired, so no special case is needed here.
    assign w_rsv_ok    = bus.rsv_en && !bus.flush &&
                         (!r_pend[bus.rsv_addr] || w_clr[bus.rsv_addr]);
    assign bus.rsv_ok  = w_rsv_ok;
    assign bus.tap_out = r_mem[TAP_A];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            for (int r = 0; r < DEPTH; r++)
                r_mem[r] <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++)
                r_mem[r] <= w_next[r];
            if (bus.flush) begin
                r_pend <= '0;
            end else begin
                for (int r = 0; r < DEPTH; r++) begin
                    if (w_rsv_ok && bus.rsv_addr == ADDR_W'(r) && !(ZERO_REG != 0 && r == 0))
                        r_pend[r] <= 1'b1;
                    else if (w_clr[r])
                        r_pend[r] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gpr_mp.sv
// tb/tb_gpr_mp.sv - directed and randomized bench for gpr_mp against a behavioural model
module tb_gpr_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpr_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .TAP_IDX(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_data [32];
    logic        m_pend [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply A's bytes, then B's on top, so B wins where they overlap.
    function automatic logic [31:0] m_next(int r);
        logic [31:0] v = m_data[r];
        if (r == 0) return 32'h0;
        if (bus.wa_en && bus.wa_addr == 5'(r))
            for (int k = 0; k < 4; k++) if (bus.wa_be[k]) v[k*8 +: 8] = bus.wa_data[k*8 +: 8];
        if (bus.wb_en && bus.wb_addr == 5'(r))
            for (int k = 0; k < 4; k++) if (bus.wb_be[k]) v[k*8 +: 8] = bus.wb_data[k*8 +: 8];
        return v;
    endfunction

    function automatic bit m_clr(int r);
        return (bus.wa_en && bus.wa_addr == 5'(r) && bus.wa_be != 4'h0) ||
               (bus.wb_en && bus.wb_addr == 5'(r) && bus.wb_be != 4'h0);
    endfunction

    function automatic bit m_rsv_ok();
        int a = int'(bus.rsv_addr);
        return bus.rsv_en && !bus.flush && (!m_pend[a] || m_clr(a));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_data[r] = 32'h0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.flush = 0; bus.rd_addr = '0; bus.rsv_en = 0; bus.rsv_addr = '0;
        bus.wa_en = 0; bus.wa_addr = '0; bus.wa_be = '0; bus.wa_data = '0;
        bus.wb_en = 0; bus.wb_addr = '0; bus.wb_be = '0; bus.wb_data = '0;
    endtask

    // Check combinational outputs against the model, clock once, then check the tap.
    task automatic step();
        logic [31:0] nd [32];
        logic        np [32];
        bit ok;
        int a;
        #2;
        for (int i = 0; i < 2; i++) begin
            a = int'(bus.rd_addr[i*5 +: 5]);
            chk($sformatf("rd_data%0d_r%0d", i, a), bus.rd_data[i*32 +: 32], m_next(a));
            chk($sformatf("rd_ready%0d_r%0d", i, a), 32'(bus.rd_ready[i]), 32'(!m_pend[a] || m_clr(a)));
        end
        ok = m_rsv_ok();
        chk("rsv_ok", 32'(bus.rsv_ok), 32'(ok));
        for (int r = 0; r < 32; r++) begin
            nd[r] = m_next(r);
            if (bus.flush) np[r] = 1'b0;
            else if (ok && r == int'(bus.rsv_addr) && r != 0) np[r] = 1'b1;
            else if (m_clr(r)) np[r] = 1'b0;
            else np[r] = m_pend[r];
        end
        @(posedge clk);
        for (int r = 0; r < 32; r++) begin
            m_data[r] = nd[r];
            m_pend[r] = np[r];
        end
        #1;
        chk("tap_out", bus.tap_out, m_data[5]);
    endtask

    initial begin
        model_reset();
        idle();
        bus.rsv_en = 1; bus.rsv_addr = 5'd3;
        #1;
        chk("rst_tap", bus.tap_out, 32'h0);
        chk("rst_rd_ready", 32'(bus.rd_ready), 32'h3);
        chk("rst_rsv_ok", 32'(bus.rsv_ok), 32'h1);
        chk("rst_rd_data", bus.rd_data[31:0], 32'h0);
        @(negedge clk);
        rst = 0;
        idle();

        bus.wa_en = 1; bus.wa_addr = 5'd5; bus.wa_be = 4'hF; bus.wa_data = 32'hDEADBEEF;
        step();
        chk("tap_deadbeef", bus.tap_out, 32'hDEADBEEF);

        idle();
        bus.rd_addr = {5'd0, 5'd5};
        rst = 1;
        #1;
        chk("async_rst_tap", bus.tap_out, 32'h0);
        model_reset();
        #1;
        rst = 0;
        step();
        chk("r5_after_rst", bus.rd_data[31:0], 32'h0);

        idle();
        bus.wa_en = 1; bus.wa_addr = 5'd7; bus.wa_be = 4'hF; bus.wa_data = 32'h11223344;
        step();
        idle();
        bus.wa_en = 1; bus.wa_addr = 5'd7; bus.wa_be = 4'b0011; bus.wa_data = 32'hAAAAAAAA;
        bus.wb_en = 1; bus.wb_addr = 5'd7; bus.wb_be = 4'b0110; bus.wb_data = 32'hBBBBBBBB;
        bus.rd_addr = {5'd0, 5'd7};
        #1;
        chk("merge_bypass", bus.rd_data[31:0], 32'h11BBBBAA);
        step();
        idle();
        bus.rd_addr = {5'd7, 5'd0};
        #1;
        chk("merge_stored", bus.rd_data[63:32], 32'h11BBBBAA);
        step();

        idle();
        bus.rsv_en = 1; bus.rsv_addr = 5'd3;
        #1;
        chk("rsv_r3_ok", 32'(bus.rsv_ok), 32'h1);
        step();
        bus.rd_addr = {5'd0, 5'd3};
        #1;
        chk("r3_not_ready", 32'(bus.rd_ready[0]), 32'h0);
        chk("rsv_r3_again", 32'(bus.rsv_ok), 32'h0);
        step();
        idle();
        bus.wb_en = 1; bus.wb_addr = 5'd3; bus.wb_be = 4'hF; bus.wb_data = 32'h5;
        bus.rd_addr = {5'd0, 5'd3};
        #1;
        chk("r3_ready_bypass", 32'(bus.rd_ready[0]), 32'h1);
        chk("r3_data_bypass", bus.rd_data[31:0], 32'h5);
        step();
        idle();
        bus.rd_addr = {5'd0, 5'd3};
        #1;
        chk("r3_pend_clear", 32'(bus.rd_ready[0]), 32'h1);
        step();

        bus.rsv_en = 1; bus.rsv_addr = 5'd9;
        step();
        idle();
        bus.wa_en = 1; bus.wa_addr = 5'd9; bus.wa_be = 4'hF; bus.wa_data = 32'h77;
        bus.rsv_en = 1; bus.rsv_addr = 5'd9;
        #1;
        chk("r9_collide_ok", 32'(bus.rsv_ok), 32'h1);
        step();
        idle();
        bus.rd_addr = {5'd0, 5'd9};
        #1;
        chk("r9_still_pend", 32'(bus.rd_ready[0]), 32'h0);
        chk("r9_data", bus.rd_data[31:0], 32'h77);
        step();

        idle();
        bus.wa_en = 1; bus.wa_addr = 5'd0; bus.wa_be = 4'hF; bus.wa_data = 32'hFFFFFFFF;
        bus.rsv_en = 1; bus.rsv_addr = 5'd0;
        #1;
        chk("r0_data", bus.rd_data[31:0], 32'h0);
        chk("r0_ready", 32'(bus.rd_ready[0]), 32'h1);
        chk("r0_rsv_ok", 32'(bus.rsv_ok), 32'h1);
        step();
        idle();
        #1;
        chk("r0_no_pend", 32'(bus.rd_ready[0]), 32'h1);
        step();

        foreach (m_data[r]) if (r == 1 || r == 2 || r == 4) begin
            idle(); bus.rsv_en = 1; bus.rsv_addr = 5'(r);
            step();
        end
        idle();
        bus.flush = 1; bus.rsv_en = 1; bus.rsv_addr = 5'd6;
        #1;
        chk("flush_rsv_ok", 32'(bus.rsv_ok), 32'h0);
        step();
        idle();
        bus.rd_addr = {5'd2, 5'd1};
        #1;
        chk("flush_ready", 32'(bus.rd_ready), 32'h3);
        step();
        bus.rd_addr = {5'd6, 5'd4};
        #1;
        chk("flush_ready2", 32'(bus.rd_ready), 32'h3);
        step();
        bus.rd_addr = {5'd9, 5'd7};
        step();

        for (int n = 0; n < 400; n++) begin
            bus.wa_en    = 1'($urandom);
            bus.wa_addr  = 5'($urandom_range(0, 11));
            bus.wa_be    = 4'($urandom);
            bus.wa_data  = $urandom;
            bus.wb_en    = 1'($urandom);
            bus.wb_addr  = 5'($urandom_range(0, 11));
            bus.wb_be    = 4'($urandom);
            bus.wb_data  = $urandom;
            bus.rsv_en   = 1'($urandom);
            bus.rsv_addr = 5'($urandom_range(0, 11));
            bus.flush    = ($urandom_range(0, 19) == 0);
            bus.rd_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
